// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one byte-addressed memory between fetch and data ports, with one transaction in flight.
// Grant to rvalid takes 2 cycles (load/word store), 3 (byte/half store via read-modify-write) or 1 (rejected store); requesters hold req until granted.
module mem_arbiter #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [1:0]        d_size_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic              d_err_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [AWIDTH-1:0] cap_addr;
    logic [DWIDTH-1:0] cap_wdata;
    logic [1:0]        cap_size;
    logic              cap_data;
    logic [DWIDTH-1:0] rmw_word;
    logic [DWIDTH-1:0] merged_word;
    logic [AWIDTH-1:0] word_addr;
    logic              last_data;

    logic              st_word_ok;
    logic              st_sub_ok;
    logic              st_err;

    // Store classification looks at the live request; it only matters on the grant cycle.
    assign st_word_ok = (d_size_i == 2'b10) && (d_addr_i[1:0] == 2'b00);
    assign st_sub_ok  = (d_size_i == 2'b00) || ((d_size_i == 2'b01) && !d_addr_i[0]);
    assign st_err     = d_gnt_o && d_we_i && !st_word_ok && !st_sub_ok;

    assign word_addr  = {cap_addr[AWIDTH-1:2], 2'b00};

    always_comb begin
        merged_word = rmw_word;
        if (cap_size == 2'b00) begin
            case (cap_addr[1:0])
                2'd0:    merged_word[7:0]   = cap_wdata[7:0];
                2'd1:    merged_word[15:8]  = cap_wdata[7:0];
                2'd2:    merged_word[23:16] = cap_wdata[7:0];
                default: merged_word[31:24] = cap_wdata[7:0];
            endcase
        end else if (cap_addr[1]) begin
            merged_word[31:16] = cap_wdata[15:0];
        end else begin
            merged_word[15:0] = cap_wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (if_gnt_o) begin
                    next_state = RD;
                end else if (d_gnt_o) begin
                    if (!d_we_i) begin
                        next_state = RD;
                    end else if (st_word_ok) begin
                        next_state = WR;
                    end else if (st_sub_ok) begin
                        next_state = RMW_RD;
                    end
                end
            end
            RD:      next_state = IDLE;
            WR:      next_state = IDLE;
            RMW_RD:  next_state = RMW_WR;
            RMW_WR:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        if_gnt_o       = 1'b0;
        d_gnt_o        = 1'b0;
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        busy_o         = (state != IDLE);
        // Grants are suppressed while reset is held so nothing is accepted mid-reset.
        if (rst && (state == IDLE)) begin
            if (if_req_i && d_req_i) begin
                if_gnt_o = last_data;
                d_gnt_o  = !last_data;
            end else begin
                if_gnt_o = if_req_i;
                d_gnt_o  = d_req_i;
            end
        end
        case (state)
            RD: begin
                mem_read_en_o = 1'b1;
                mem_addr_o    = cap_addr;
            end
            WR: begin
                mem_write_en_o = 1'b1;
                mem_addr_o     = word_addr;
                mem_data_o     = cap_wdata;
            end
            RMW_RD: begin
                mem_read_en_o = 1'b1;
                mem_addr_o    = word_addr;
            end
            RMW_WR: begin
                mem_write_en_o = 1'b1;
                mem_addr_o     = word_addr;
                mem_data_o     = merged_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_addr    <= '0;
            cap_wdata   <= '0;
            cap_size    <= 2'b00;
            cap_data    <= 1'b0;
            rmw_word    <= '0;
            last_data   <= 1'b1;
            if_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            d_rvalid_o  <= 1'b0;
            d_err_o     <= 1'b0;
            d_rdata_o   <= '0;
        end else begin
            if_rvalid_o <= 1'b0;
            d_rvalid_o  <= 1'b0;
            d_err_o     <= 1'b0;
            if (if_gnt_o) begin
                cap_addr  <= if_addr_i;
                cap_wdata <= '0;
                cap_size  <= 2'b10;
                cap_data  <= 1'b0;
                last_data <= 1'b0;
            end else if (d_gnt_o) begin
                cap_addr  <= d_addr_i;
                cap_wdata <= d_wdata_i;
                cap_size  <= d_size_i;
                cap_data  <= 1'b1;
                last_data <= 1'b1;
                if (st_err) begin
                    d_rvalid_o <= 1'b1;
                    d_err_o    <= 1'b1;
                    d_rdata_o  <= '0;
                end
            end
            case (state)
                RD: begin
                    if (cap_data) begin
                        d_rvalid_o <= 1'b1;
                        d_rdata_o  <= mem_data_i;
                    end else begin
                        if_rvalid_o <= 1'b1;
                        if_rdata_o  <= mem_data_i;
                    end
                end
                WR, RMW_WR: begin
                    d_rvalid_o <= 1'b1;
                    d_rdata_o  <= '0;
                end
                RMW_RD:  rmw_word <= mem_data_i;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written reset/arbitration sequences and a random run against a transaction-level model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i, d_we_i;
    logic [1:0]  d_size_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0] d_rdata_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic        mem_read_en_o, mem_write_en_o, busy_o;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mem_data_i = mem[mem_addr_o[7:2]];
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_dat;
        else if (mem_write_en_o) mem[mem_addr_o[7:2]] <= mem_data_o;
    end

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_err_o(d_err_o), .d_rdata_o(d_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_data_i(mem_data_i), .busy_o(busy_o)
    );

    typedef struct {
        bit          pre;
        bit          is_data;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic [31:0] exp_word;
        int          exp_lat;
        int          exp_err;
        int          exp_writes;
        int          exp_busy;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_size_i = 2'b00; d_addr_i = '0; d_wdata_i = '0;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_dat = val;
        ref_mem[idx] = val;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int g, r, nrv, nw, nb, nboth, nerr;
        logic [31:0] rd;
        v = vecs[i];
        if (v.pre) preload(v.addr[7:2], v.init);
        g = -1; r = -1; nrv = 0; nw = 0; nb = 0; nboth = 0; nerr = 0; rd = '0;
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            if (v.is_data) begin
                d_req_i = (g < 0); d_we_i = v.we; d_size_i = v.size;
                d_addr_i = v.addr; d_wdata_i = v.wdata;
            end else begin
                if_req_i = (g < 0); if_addr_i = v.addr;
            end
            #1;
            if ((v.is_data ? d_gnt_o : if_gnt_o) && g < 0) g = c;
            if (v.is_data ? d_rvalid_o : if_rvalid_o) begin
                nrv++; r = c;
                rd = v.is_data ? d_rdata_o : if_rdata_o;
            end
            if (d_err_o) nerr++;
            if (mem_write_en_o) nw++;
            if (busy_o) nb++;
            if (mem_read_en_o && mem_write_en_o) nboth++;
            tick();
        end
        idle_inputs();
        check($sformatf("v%0d latency", i), r - g, v.exp_lat);
        check($sformatf("v%0d rvalid_pulses", i), nrv, 1);
        check($sformatf("v%0d rdata", i), rd, v.exp_rdata);
        check($sformatf("v%0d err_pulses", i), nerr, v.exp_err);
        check($sformatf("v%0d mem_writes", i), nw, v.exp_writes);
        check($sformatf("v%0d busy_cycles", i), nb, v.exp_busy);
        check($sformatf("v%0d rd_wr_overlap", i), nboth, 0);
        check($sformatf("v%0d mem_word", i), mem[v.addr[7:2]], v.exp_word);
    endtask

    // Transaction-level effect of one accepted request: returns latency, response data and error flag.
    task automatic model_txn(input bit is_data, input bit we, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output logic [31:0] rd, output bit err);
        logic [5:0] idx;
        bit mis;
        int lane;
        idx = a[7:2];
        err = 1'b0; rd = '0;
        if (!is_data || !we) begin
            rd = ref_mem[idx];
            lat = 2;
        end else begin
            mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
            if (mis) begin
                err = 1'b1;
                lat = 1;
            end else begin
                for (int b = 0; b < (1 << sz); b++) begin
                    lane = int'(a[1:0]) + b;
                    ref_mem[idx][8*lane +: 8] = wd[8*b +: 8];
                end
                lat = (sz == 2'd2) ? 2 : 3;
            end
        end
    endtask

    initial begin
        vec_t tmp;
        int ng, r;
        bit exp_f;
        bit f_pend, d_pend, dw, last_d, e_vld, e_data, e_err, egf, egd, xf, xd;
        logic [1:0] ds;
        logic [31:0] f_addr, da, dwd, e_rd, m_rd;
        int free_at, gcyc, e_due, lat;

        //               pre is_d we  size   addr          wdata         init          exp_rdata     exp_word      lat err wr busy
        vecs[0]  = '{1, 0, 0, 2'd2, 32'h01000000, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2, 0, 0, 1};
        vecs[1]  = '{1, 1, 0, 2'd0, 32'h01000007, 32'h0,        32'h55667788, 32'h55667788, 32'h55667788, 2, 0, 0, 1};
        vecs[2]  = '{1, 1, 1, 2'd0, 32'h01000002, 32'h000000AB, 32'h11223344, 32'h0,        32'h11AB3344, 3, 0, 1, 2};
        vecs[3]  = '{1, 1, 1, 2'd1, 32'h01000001, 32'h0000BEEF, 32'h11223344, 32'h0,        32'h11223344, 1, 1, 0, 0};
        vecs[4]  = '{1, 1, 1, 2'd2, 32'h01000004, 32'hCAFEF00D, 32'h00000000, 32'h0,        32'hCAFEF00D, 2, 0, 1, 1};
        vecs[5]  = '{1, 1, 1, 2'd1, 32'h0100000A, 32'h0000BEEF, 32'h11223344, 32'h0,        32'hBEEF3344, 3, 0, 1, 2};
        vecs[6]  = '{1, 1, 1, 2'd3, 32'h01000008, 32'h12345678, 32'h11223344, 32'h0,        32'h11223344, 1, 1, 0, 0};
        vecs[7]  = '{1, 1, 1, 2'd2, 32'h0100000A, 32'h12345678, 32'h11223344, 32'h0,        32'h11223344, 1, 1, 0, 0};
        vecs[8]  = '{1, 1, 1, 2'd0, 32'h0100000D, 32'hFFFFFF5A, 32'hAABBCCDD, 32'h0,        32'hAABB5ADD, 3, 0, 1, 2};
        vecs[9]  = '{1, 1, 1, 2'd1, 32'h01000010, 32'hABCD1234, 32'hFFFFFFFF, 32'h0,        32'hFFFF1234, 3, 0, 1, 2};
        vecs[10] = '{0, 1, 0, 2'd2, 32'h01000004, 32'h0,        32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 2, 0, 0, 1};

        idle_inputs();
        rst = 1'b0;
        if_req_i = 1'b1; d_req_i = 1'b1;
        tick(); tick();
        check("reset ctrl outputs",
              {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, d_err_o, mem_read_en_o, mem_write_en_o, busy_o}, 8'h00);
        check("reset if_rdata", if_rdata_o, 32'h0);
        check("reset d_rdata", d_rdata_o, 32'h0);
        check("reset mem_addr", mem_addr_o, 32'h0);
        idle_inputs();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) run_vec(i);

        // Both requesters continuously loading from a fresh reset: grants must alternate starting with fetch.
        rst = 1'b0; tick(); rst = 1'b1;
        if_req_i = 1'b1; if_addr_i = 32'h01000000;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h01000004;
        ng = 0; exp_f = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (if_gnt_o || d_gnt_o) begin
                check($sformatf("rr grant %0d", ng), {30'b0, if_gnt_o, d_gnt_o}, {30'b0, exp_f, !exp_f});
                exp_f = !exp_f;
                ng++;
            end
            tick();
        end
        check("rr grant count", ng, 6);
        idle_inputs();
        tick(); tick();

        // Reset asserted while a byte store is in its read phase.
        preload(6'd5, 32'h11223344);
        d_req_i = 1'b1; d_we_i = 1'b1; d_size_i = 2'b00; d_addr_i = 32'h01000014; d_wdata_i = 32'h000000AB;
        #1;
        check("rmw abort grant", d_gnt_o, 1'b1);
        tick();
        idle_inputs();
        #1;
        check("rmw abort in read phase", {mem_read_en_o, busy_o}, 2'b11);
        rst = 1'b0;
        #1;
        check("rmw abort ctrl outputs",
              {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, d_err_o, mem_read_en_o, mem_write_en_o, busy_o}, 8'h00);
        check("rmw abort rdata", if_rdata_o | d_rdata_o, 32'h0);
        r = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (mem_write_en_o || d_rvalid_o) r++;
        end
        rst = 1'b1;
        check("rmw abort no write/resp", r, 0);
        check("rmw abort mem word", mem[5], 32'h11223344);
        if_req_i = 1'b1; if_addr_i = 32'h01000014;
        r = -1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c == 0) check("post-reset fetch grant", if_gnt_o, 1'b1);
            if (if_rvalid_o) begin
                r = c;
                check("post-reset fetch data", if_rdata_o, 32'h11223344);
            end
            if (d_rvalid_o) r = 99;
            tick();
            if_req_i = 1'b0;
        end
        check("post-reset fetch latency", r, 2);

        // Random traffic against the transaction-level model.
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 64; i++) preload(i[5:0], $urandom);
        rst = 1'b1;
        f_pend = 0; d_pend = 0; last_d = 1; e_vld = 0; e_data = 0; e_err = 0; e_rd = '0; e_due = -1;
        free_at = 0; gcyc = -100;
        f_addr = '0; da = '0; dwd = '0; ds = '0; dw = 0;
        for (int c = 0; c < 600; c++) begin
            if (!f_pend && $urandom_range(0, 2) == 0) begin
                f_pend = 1; f_addr = 32'h01000000 | 32'($urandom_range(0, 63));
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; dw = 1'($urandom_range(0, 1)); ds = 2'($urandom_range(0, 3));
                da = 32'h01000000 | 32'($urandom_range(0, 63)); dwd = $urandom;
            end
            if_req_i = f_pend; if_addr_i = f_addr;
            d_req_i = d_pend; d_we_i = dw; d_size_i = ds; d_addr_i = da; d_wdata_i = dwd;
            #1;
            egf = 0; egd = 0;
            if (c >= free_at && (f_pend || d_pend)) begin
                if (f_pend && d_pend) begin egf = last_d; egd = !last_d; end
                else begin egf = f_pend; egd = d_pend; end
            end
            check($sformatf("rand c%0d grant", c), {30'b0, if_gnt_o, d_gnt_o}, {30'b0, egf, egd});
            xf = e_vld && e_due == c && !e_data;
            xd = e_vld && e_due == c && e_data;
            check($sformatf("rand c%0d resp", c), {29'b0, if_rvalid_o, d_rvalid_o, d_err_o},
                  {29'b0, xf, xd, xd && e_err});
            if (xf) check($sformatf("rand c%0d if_rdata", c), if_rdata_o, e_rd);
            if (xd) check($sformatf("rand c%0d d_rdata", c), d_rdata_o, e_rd);
            check($sformatf("rand c%0d busy", c), busy_o, (c > gcyc) && (c < free_at));
            if (e_vld && e_due == c) e_vld = 0;
            if (egf || egd) begin
                if (egf) model_txn(0, 0, 2'd2, f_addr, 32'h0, lat, m_rd, e_err);
                else model_txn(1, dw, ds, da, dwd, lat, m_rd, e_err);
                e_vld = 1; e_data = egd; e_due = c + lat; e_rd = m_rd;
                gcyc = c; free_at = c + lat; last_d = egd;
                if (egf) f_pend = 0; else d_pend = 0;
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) tick();
        for (int i = 0; i < 16; i++) check($sformatf("rand mem word %0d", i), mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
